// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - scoreboard-based hazard, stall, flush and forwarding control
//
// Purpose:
//    Tracks pending long-latency register writes (loads, mul/div) in a
//    per-register busy vector. Stalls ID on RAW/WAW against pending writes
//    and when too many long ops are in flight. Selects EX/MEM/WB forwarding
//    sources. Holds IF/ID flush for FLUSH_CYC cycles after a redirect.
//    Keeps saturating stall/flush counters.
//
// Ports:
//    i_clk, i_reset             clock, async active-low reset
//    id_*                       ID-stage instruction: valid, sources, dest, long flag
//    ex_*/mem_*/wb_*            downstream producers: valid, rd, rd_wren, long flag
//    redirect                   taken branch / resolved jump in EX
//    o_en_pc/o_en_if/o_en_id    stage enables (0 = hold)
//    o_flush_if_n/o_flush_id_n  active-low synchronous clear of IF/ID registers
//    o_issue                    ID instruction advances into EX this cycle
//    forward_a/forward_b        11 EX, 10 MEM, 01 WB, 00 register file
//    o_sb_busy                  scoreboard busy bits
//    o_outstanding              long ops in flight
//    o_stall_cnt/o_flush_cnt    saturating performance counters
//    o_err                      sticky: long completion seen with nothing in flight

module hazard_scoreboard #(
   parameter int NREG      = 32,
   parameter int AW        = 5,
   parameter int MAX_OUT   = 4,
   parameter int OW        = 3,
   parameter int FLUSH_CYC = 1,
   parameter int CNT_W     = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             id_valid,
   input  logic [AW-1:0]    id_rs1,
   input  logic [AW-1:0]    id_rs2,
   input  logic             id_rs1_use,
   input  logic             id_rs2_use,
   input  logic [AW-1:0]    id_rd,
   input  logic             id_rd_wren,
   input  logic             id_long,
   input  logic             ex_valid,
   input  logic [AW-1:0]    ex_rd,
   input  logic             ex_rd_wren,
   input  logic             ex_long,
   input  logic             mem_valid,
   input  logic [AW-1:0]    mem_rd,
   input  logic             mem_rd_wren,
   input  logic             mem_long,
   input  logic             wb_valid,
   input  logic [AW-1:0]    wb_rd,
   input  logic             wb_rd_wren,
   input  logic             wb_long,
   input  logic             redirect,
   output logic             o_en_pc,
   output logic             o_en_if,
   output logic             o_en_id,
   output logic             o_flush_if_n,
   output logic             o_flush_id_n,
   output logic             o_issue,
   output logic [1:0]       forward_a,
   output logic [1:0]       forward_b,
   output logic [NREG-1:0]  o_sb_busy,
   output logic [OW-1:0]    o_outstanding,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt,
   output logic             o_err
);

   localparam int TW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

   logic [NREG-1:0]  sb;
   logic [OW-1:0]    outstanding;
   logic [TW-1:0]    flush_tmr;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic             err;

   logic            wb_cpl;
   logic [NREG-1:0] clr_mask;
   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] busy_eff;
   logic            hz_rs1;
   logic            hz_rs2;
   logic            hz_rd;
   logic            hz_cap;
   logic            hz;
   logic            flush;
   logic            issue;
   logic            issue_long;

   // Forwarding source for one operand. A matching long op in EX or MEM
   // has no result yet, so it shadows older matches; the scoreboard stalls.
   function automatic logic [1:0] fwd_sel(
      input logic          use_rs,
      input logic [AW-1:0] rs,
      input logic          ev,
      input logic [AW-1:0] er,
      input logic          ew,
      input logic          el,
      input logic          mv,
      input logic [AW-1:0] mr,
      input logic          mw,
      input logic          ml,
      input logic          wv,
      input logic [AW-1:0] wr,
      input logic          ww
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (use_rs && rs != '0) begin
         if (ev && ew && er == rs)
            sel = el ? 2'b00 : 2'b11;
         else if (mv && mw && mr == rs)
            sel = ml ? 2'b00 : 2'b10;
         else if (wv && ww && wr == rs)
            sel = 2'b01;
      end
      return sel;
   endfunction

   assign wb_cpl = wb_valid & wb_long;

   // Completing write clears its busy bit in the same cycle so the
   // dependent instruction in ID can issue with a WB forward.
   assign clr_mask = (wb_cpl && wb_rd_wren && wb_rd != '0) ? (NREG'(1) << wb_rd) : '0;
   assign busy_eff = sb & ~clr_mask;

   assign hz_rs1 = id_rs1_use & (id_rs1 != '0) & busy_eff[id_rs1];
   assign hz_rs2 = id_rs2_use & (id_rs2 != '0) & busy_eff[id_rs2];
   assign hz_rd  = id_rd_wren & (id_rd != '0) & busy_eff[id_rd];
   assign hz_cap = id_long & (outstanding == OW'(MAX_OUT)) & ~wb_cpl;
   assign hz     = id_valid & (hz_rs1 | hz_rs2 | hz_rd | hz_cap);

   assign flush      = redirect | (flush_tmr != '0);
   assign issue      = id_valid & ~hz & ~flush;
   assign issue_long = issue & id_long;

   assign set_mask = (issue_long && id_rd_wren && id_rd != '0) ? (NREG'(1) << id_rd) : '0;

   // Flush forces every stage to advance so the squashed slots drain.
   assign o_en_pc      = flush | ~hz;
   assign o_en_if      = flush | ~hz;
   assign o_en_id      = flush | ~hz;
   assign o_flush_if_n = i_reset & ~flush;
   assign o_flush_id_n = i_reset & ~flush;
   assign o_issue      = issue;

   assign forward_a = fwd_sel(id_rs1_use, id_rs1, ex_valid, ex_rd, ex_rd_wren, ex_long,
                              mem_valid, mem_rd, mem_rd_wren, mem_long,
                              wb_valid, wb_rd, wb_rd_wren);
   assign forward_b = fwd_sel(id_rs2_use, id_rs2, ex_valid, ex_rd, ex_rd_wren, ex_long,
                              mem_valid, mem_rd, mem_rd_wren, mem_long,
                              wb_valid, wb_rd, wb_rd_wren);

   assign o_sb_busy     = sb;
   assign o_outstanding = outstanding;
   assign o_stall_cnt   = stall_cnt;
   assign o_flush_cnt   = flush_cnt;
   assign o_err         = err;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         sb          <= '0;
         outstanding <= '0;
         flush_tmr   <= '0;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
         err         <= 1'b0;
      end else begin
         // Set applied after clear so a same-index set wins.
         sb <= (sb & ~clr_mask) | set_mask;

         if (issue_long && !wb_cpl) begin
            outstanding <= outstanding + 1'b1;
         end else if (!issue_long && wb_cpl) begin
            if (outstanding == '0)
               err <= 1'b1;
            else
               outstanding <= outstanding - 1'b1;
         end

         // A new redirect restarts the window even if one is running.
         if (redirect)
            flush_tmr <= TW'(FLUSH_CYC - 1);
         else if (flush_tmr != '0)
            flush_tmr <= flush_tmr - 1'b1;

         if (hz && !flush && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
         if (flush && flush_cnt != '1)
            flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed vector bench for hazard_scoreboard

module tb_hazard_scoreboard;

   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam int OW   = 3;
   localparam int CW   = 8;

   logic            clk;
   logic            rst_n;
   logic            id_valid, id_rs1_use, id_rs2_use, id_rd_wren, id_long;
   logic [AW-1:0]   id_rs1, id_rs2, id_rd;
   logic            ex_valid, ex_rd_wren, ex_long;
   logic [AW-1:0]   ex_rd;
   logic            mem_valid, mem_rd_wren, mem_long;
   logic [AW-1:0]   mem_rd;
   logic            wb_valid, wb_rd_wren, wb_long;
   logic [AW-1:0]   wb_rd;
   logic            redirect;
   logic            en_pc, en_if, en_id, flush_if_n, flush_id_n, issue, err;
   logic [1:0]      fa, fb;
   logic [NREG-1:0] sb_busy;
   logic [OW-1:0]   outstanding;
   logic [CW-1:0]   stall_cnt, flush_cnt;

   int n_chk;
   int n_fail;

   hazard_scoreboard #(
      .NREG(NREG), .AW(AW), .MAX_OUT(4), .OW(OW), .FLUSH_CYC(2), .CNT_W(CW)
   ) dut (
      .i_clk(clk), .i_reset(rst_n),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
      .id_rd(id_rd), .id_rd_wren(id_rd_wren), .id_long(id_long),
      .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_rd_wren(ex_rd_wren), .ex_long(ex_long),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_rd_wren(mem_rd_wren), .mem_long(mem_long),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_rd_wren(wb_rd_wren), .wb_long(wb_long),
      .redirect(redirect),
      .o_en_pc(en_pc), .o_en_if(en_if), .o_en_id(en_id),
      .o_flush_if_n(flush_if_n), .o_flush_id_n(flush_id_n),
      .o_issue(issue), .forward_a(fa), .forward_b(fb),
      .o_sb_busy(sb_busy), .o_outstanding(outstanding),
      .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt), .o_err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          id_v;
      logic [AW-1:0] rs1;
      logic          rs1_u;
      logic [AW-1:0] rs2;
      logic          rs2_u;
      logic [AW-1:0] rd;
      logic          rd_w;
      logic          ex_v;
      logic [AW-1:0] ex_r;
      logic          ex_w;
      logic          ex_l;
      logic          mem_v;
      logic [AW-1:0] mem_r;
      logic          mem_w;
      logic          mem_l;
      logic          wb_v;
      logic [AW-1:0] wb_r;
      logic          wb_w;
      logic          wb_l;
      logic          exp_issue;
      logic [1:0]    exp_fa;
      logic [1:0]    exp_fb;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_use = 0; id_rs2_use = 0;
      id_rd = 0; id_rd_wren = 0; id_long = 0;
      ex_valid = 0; ex_rd = 0; ex_rd_wren = 0; ex_long = 0;
      mem_valid = 0; mem_rd = 0; mem_rd_wren = 0; mem_long = 0;
      wb_valid = 0; wb_rd = 0; wb_rd_wren = 0; wb_long = 0;
      redirect = 0;
   endtask

   // Advance to just after the next falling edge; state has updated.
   task automatic next_cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 0;
      #1;
      rst_n = 1;
      next_cyc();
   endtask

   task automatic id_load(input logic [AW-1:0] rd);
      idle();
      id_valid = 1; id_long = 1; id_rd = rd; id_rd_wren = 1;
   endtask

   task automatic wb_cpl(input logic [AW-1:0] rd);
      wb_valid = 1; wb_long = 1; wb_rd = rd; wb_rd_wren = 1;
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst_n = 0;
      idle();

      //              id  rs1 u rs2 u rd w | ex v rd w l | mem v rd w l | wb v rd w l | iss fa fb
      vecs[0] = '{1, 3, 1, 7, 1, 8, 1,  1, 7, 1, 0,  1, 7, 1, 0,  0, 0, 0, 0,  1, 2'b00, 2'b11};
      vecs[1] = '{1, 3, 1, 7, 0, 8, 1,  1, 7, 1, 0,  1, 7, 1, 0,  0, 0, 0, 0,  1, 2'b00, 2'b00};
      vecs[2] = '{1, 3, 1, 0, 1, 8, 1,  1, 0, 1, 0,  1, 0, 1, 0,  0, 0, 0, 0,  1, 2'b00, 2'b00};
      vecs[3] = '{1, 9, 1, 7, 1, 8, 1,  1, 9, 1, 0,  1, 7, 1, 0,  0, 0, 0, 0,  1, 2'b11, 2'b10};
      vecs[4] = '{1, 7, 1, 2, 1, 8, 1,  0, 0, 0, 0,  0, 0, 0, 0,  1, 7, 1, 0,  1, 2'b01, 2'b00};
      vecs[5] = '{1, 7, 1, 4, 1, 8, 1,  1, 7, 1, 1,  1, 7, 1, 0,  1, 4, 1, 0,  1, 2'b00, 2'b01};
      vecs[6] = '{1, 7, 1, 3, 1, 8, 1,  1, 3, 1, 0,  1, 7, 1, 1,  1, 7, 1, 0,  1, 2'b00, 2'b11};
      vecs[7] = '{1, 7, 1, 5, 1, 8, 1,  0, 7, 1, 0,  1, 7, 1, 0,  0, 0, 0, 0,  1, 2'b10, 2'b00};
      vecs[8] = '{1, 1, 1, 7, 1, 8, 1,  1, 7, 0, 0,  0, 0, 0, 0,  1, 7, 1, 0,  1, 2'b00, 2'b01};
      vecs[9] = '{0, 7, 1, 0, 0, 0, 0,  1, 7, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 2'b11, 2'b00};

      // Reset state
      next_cyc();
      next_cyc();
      chk("rst_flush_if_n", flush_if_n, 0);
      chk("rst_flush_id_n", flush_id_n, 0);
      chk("rst_sb", sb_busy, 0);
      chk("rst_out", outstanding, 0);
      chk("rst_stall", stall_cnt, 0);
      chk("rst_flushcnt", flush_cnt, 0);
      chk("rst_err", err, 0);
      rst_n = 1;
      next_cyc();

      // Table: forwarding and issue with an empty scoreboard
      for (int i = 0; i < 10; i++) begin
         idle();
         id_valid = vecs[i].id_v; id_rs1 = vecs[i].rs1; id_rs1_use = vecs[i].rs1_u;
         id_rs2 = vecs[i].rs2; id_rs2_use = vecs[i].rs2_u; id_rd = vecs[i].rd;
         id_rd_wren = vecs[i].rd_w;
         ex_valid = vecs[i].ex_v; ex_rd = vecs[i].ex_r; ex_rd_wren = vecs[i].ex_w; ex_long = vecs[i].ex_l;
         mem_valid = vecs[i].mem_v; mem_rd = vecs[i].mem_r; mem_rd_wren = vecs[i].mem_w; mem_long = vecs[i].mem_l;
         wb_valid = vecs[i].wb_v; wb_rd = vecs[i].wb_r; wb_rd_wren = vecs[i].wb_w; wb_long = vecs[i].wb_l;
         #1;
         chk($sformatf("v%0d_issue", i), issue, vecs[i].exp_issue);
         chk($sformatf("v%0d_fa", i), fa, vecs[i].exp_fa);
         chk($sformatf("v%0d_fb", i), fb, vecs[i].exp_fb);
         chk($sformatf("v%0d_en", i), {en_pc, en_if, en_id}, 3'b111);
         chk($sformatf("v%0d_flush_n", i), {flush_if_n, flush_id_n}, 2'b11);
         next_cyc();
      end
      idle();
      chk("tbl_stall", stall_cnt, 0);

      // Load-use: lw x5 then add x6,x5,x1
      pulse_reset();
      id_load(5); id_rs1 = 1; id_rs1_use = 1;
      #1 chk("lu_lw_issue", issue, 1);
      next_cyc();
      chk("lu_sb", sb_busy, 32'h0000_0020);
      chk("lu_out", outstanding, 1);
      idle();
      id_valid = 1; id_rs1 = 5; id_rs1_use = 1; id_rs2 = 1; id_rs2_use = 1; id_rd = 6; id_rd_wren = 1;
      ex_valid = 1; ex_rd = 5; ex_rd_wren = 1; ex_long = 1;
      #1 chk("lu_stall1_en", {en_pc, en_if, en_id}, 3'b000);
      chk("lu_stall1_issue", issue, 0);
      next_cyc();
      ex_valid = 0; mem_valid = 1; mem_rd = 5; mem_rd_wren = 1; mem_long = 1;
      #1 chk("lu_stall2_issue", issue, 0);
      next_cyc();
      mem_valid = 0; wb_cpl(5);
      #1 chk("lu_cpl_issue", issue, 1);
      chk("lu_cpl_fa", fa, 2'b01);
      chk("lu_cpl_en", en_pc, 1);
      next_cyc();
      idle();
      chk("lu_sb_clr", sb_busy, 0);
      chk("lu_out_clr", outstanding, 0);
      chk("lu_stall_cnt", stall_cnt, 2);
      chk("lu_err", err, 0);

      // Outstanding limit
      pulse_reset();
      for (int r = 1; r <= 4; r++) begin
         id_load(AW'(r));
         next_cyc();
      end
      chk("cap_out4", outstanding, 4);
      chk("cap_sb", sb_busy, 32'h0000_001E);
      id_load(8);
      #1 chk("cap_stall_issue", issue, 0);
      chk("cap_stall_en", en_id, 0);
      next_cyc();
      wb_cpl(1);
      #1 chk("cap_cpl_issue", issue, 1);
      next_cyc();
      chk("cap_out_same", outstanding, 4);
      chk("cap_sb2", sb_busy, 32'h0000_011C);
      chk("cap_stall_cnt", stall_cnt, 1);
      idle(); wb_cpl(2); next_cyc();
      idle(); wb_cpl(3); next_cyc();
      idle(); wb_cpl(4); next_cyc();
      idle(); wb_cpl(8); next_cyc();
      idle();
      chk("cap_drain_out", outstanding, 0);
      chk("cap_drain_sb", sb_busy, 0);
      chk("cap_drain_err", err, 0);

      // Flush window with FLUSH_CYC=2, redirect retriggered
      pulse_reset();
      idle(); id_valid = 1; redirect = 1;
      #1 chk("fl_t0_n", {flush_if_n, flush_id_n}, 2'b00);
      chk("fl_t0_en", {en_pc, en_if, en_id}, 3'b111);
      chk("fl_t0_issue", issue, 0);
      next_cyc();
      #1 chk("fl_t1_n", {flush_if_n, flush_id_n}, 2'b00);
      next_cyc();
      redirect = 0;
      #1 chk("fl_t2_n", {flush_if_n, flush_id_n}, 2'b00);
      chk("fl_t2_issue", issue, 0);
      next_cyc();
      #1 chk("fl_t3_n", {flush_if_n, flush_id_n}, 2'b11);
      chk("fl_t3_issue", issue, 1);
      chk("fl_cnt", flush_cnt, 3);
      idle();

      // Redirect during a stall, then async reset mid-stall
      pulse_reset();
      id_load(10);
      next_cyc();
      idle(); id_valid = 1; id_rs1 = 10; id_rs1_use = 1; redirect = 1;
      #1 chk("rs_en", {en_pc, en_if, en_id}, 3'b111);
      chk("rs_issue", issue, 0);
      next_cyc();
      chk("rs_stall_cnt0", stall_cnt, 0);
      redirect = 0;
      next_cyc();
      chk("rs_stall_cnt1", stall_cnt, 0);
      chk("rs_flush_cnt", flush_cnt, 2);
      next_cyc();
      chk("rs_stall_cnt2", stall_cnt, 1);
      chk("rs_out", outstanding, 1);
      #2 rst_n = 0;
      #1 chk("ar_sb", sb_busy, 0);
      chk("ar_out", outstanding, 0);
      chk("ar_stall", stall_cnt, 0);
      chk("ar_flush", flush_cnt, 0);
      chk("ar_flush_n", flush_if_n, 0);
      next_cyc();
      rst_n = 1;
      idle();
      next_cyc();

      // Completion with nothing in flight: sticky error
      wb_cpl(3);
      next_cyc();
      idle();
      chk("err_set", err, 1);
      chk("err_out", outstanding, 0);
      repeat (3) next_cyc();
      chk("err_sticky", err, 1);
      pulse_reset();
      chk("err_clr", err, 0);

      // Counter saturation
      redirect = 1;
      repeat (260) next_cyc();
      chk("sat_flush", flush_cnt, 8'hFF);
      idle();
      pulse_reset();
      id_load(11);
      next_cyc();
      idle(); id_valid = 1; id_rs2 = 11; id_rs2_use = 1;
      repeat (260) next_cyc();
      chk("sat_stall", stall_cnt, 8'hFF);
      chk("sat_flush0", flush_cnt, 0);
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
